axi4l_regbank: RTL and testbench
================================

# axi4l_regbank

AXI4-Lite slave register bank that sits directly downstream of the APB3-to-AXI4-Lite bridge and terminates its AW/W/B and AR/R channels. It holds NUM_REGS full-word read/write registers and exposes them to core logic as a flat vector with per-register write strobes. Addresses outside the bank return SLVERR. The bridge maps SLVERR to pslverr.

## Interface
Parameters:
- ADDR_WIDTH, 12: AXI address width; max 32.
- DATA_WIDTH, 32: register and data width; max 32.
- NUM_REGS, 8: number of registers, 1..2^(ADDR_WIDTH-2).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- resetn  in  1  reset, asynchronous, active-low.
- awaddr  in  ADDR_WIDTH  write address.
- awvalid  in  1  write address valid.
- awready  out  1  write address ready.
- wdata  in  DATA_WIDTH  write data; no strobes, full-word writes only.
- wvalid  in  1  write data valid.
- wready  out  1  write data ready.
- bresp  out  2  write response.
- bvalid  out  1  write response valid.
- bready  in  1  write response ready.
- araddr  in  ADDR_WIDTH  read address.
- arvalid  in  1  read address valid.
- arready  out  1  read address ready.
- rdata  out  DATA_WIDTH  read data.
- rresp  out  2  read response.
- rvalid  out  1  read valid.
- rready  in  1  read ready.
- reg_q  out  NUM_REGS*DATA_WIDTH  register contents; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- reg_wr  out  NUM_REGS  one-cycle pulse, bit i high in the cycle after register i is written.

## Operation
- Decode: index = addr[ADDR_WIDTH-1:2]. addr[1:0] is ignored. The address is in range when index < NUM_REGS.
- Write path: AW and W are captured independently into one-entry buffers (aw_full, w_full).
  - awready = ~aw_full; wready = ~w_full. AW may arrive before, with, or after W.
  - Commit condition: aw_full & w_full & (~bvalid | bready).
  - On commit, in range: register[index] <= wdata, bresp <= OKAY (2'b00), reg_wr[index] pulses.
  - On commit, out of range: no register changes, bresp <= SLVERR (2'b10), reg_wr stays 0.
  - Commit clears both buffers and sets bvalid. bvalid clears on bvalid & bready unless a new commit happens in the same cycle.
- Read path: arready = ~rvalid | rready.
  - On AR handshake, in range: rdata <= register[index], rresp <= OKAY.
  - On AR handshake, out of range: rdata <= 0, rresp <= SLVERR.
  - rvalid is set on the AR handshake and held until rready. rdata and rresp stay stable while rvalid & ~rready.
- Read and write are fully independent. If a read and a write commit hit the same register on the same edge, the read returns the old value.
- Reset values: awready=1, wready=1, arready=1, bvalid=0, bresp=0, rvalid=0, rresp=0, rdata=0, reg_q=0, reg_wr=0, buffers empty.
- Reset asserted mid-transaction drops all buffered and pending responses; no register is written.

## Timing
- Write: bvalid rises 1 cycle after the later of the AW and W handshakes, provided B is free. reg_q updates on that same edge, and reg_wr is high during that cycle.
- When bready is held high, one write completes every 2 cycles.
- Read: rvalid rises 1 cycle after the AR handshake. With rready=1, back-to-back reads sustain one read per cycle.
- If B is stalled (bvalid & ~bready), one further AW/W pair is buffered. The pair commits on the edge where bready is seen.
- awready, wready and arready are combinational from internal state and the ready inputs only; there is no valid-to-ready path.

## Structure
- Shared package axi4l_pkg holds the response constants RESP_OKAY=2'b00, RESP_SLVERR=2'b10. The bridge will use the same package.
- Single module; no sub-module. The register array is a generate loop over NUM_REGS.

## Test plan
- Reset: resetn low then high -> all outputs at their reset values; a read of addr 0x004 -> rdata 0, rresp 2'b00.
- Write 0xDEADBEEF to 0x008 with AW one cycle before W, bready=1 -> bvalid 1 cycle after the W handshake, bresp 2'b00, reg_wr=8'b0000_0100, reg_q[95:64]=0xDEADBEEF; readback returns 0xDEADBEEF.
- Write to 0x020 and read 0x03C with NUM_REGS=8 -> bresp 2'b10 and rresp 2'b10 with rdata 0; reg_q unchanged; reg_wr stays 0.
- bready held low for 5 cycles with a second AW/W pair offered -> second pair accepted, awready/wready then low; the second commit occurs on the edge where bready rises; both bresp are 2'b00.
- Same-edge read and write to 0x000 (old value 0x1, new value 0x2) -> rdata 0x1; a subsequent read returns 0x2.
- resetn asserted while aw_full=1 and w_full=0 -> after release, no bvalid, register unchanged, awready=1.

Source files
------------

// File: rtl/axi4l_pkg.sv
// Shared AXI4-Lite definitions used by the register bank and the APB3 bridge.
package axi4l_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4l_regbank.sv
// AXI4-Lite slave holding NUM_REGS full-word registers, exposed to core logic
// as a flat vector with one-cycle write pulses; unmapped addresses get SLVERR.
module axi4l_regbank
  import axi4l_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic [ADDR_WIDTH-1:0]          awaddr,
  input  logic                           awvalid,
  output logic                           awready,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic                           wvalid,
  output logic                           wready,
  output logic [1:0]                     bresp,
  output logic                           bvalid,
  input  logic                           bready,
  input  logic [ADDR_WIDTH-1:0]          araddr,
  input  logic                           arvalid,
  output logic                           arready,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [1:0]                     rresp,
  output logic                           rvalid,
  input  logic                           rready,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr
);

  localparam int IDX_W = ADDR_WIDTH - 2;

  logic                  aw_full;
  logic                  w_full;
  logic [IDX_W-1:0]      aw_idx_q;
  logic [DATA_WIDTH-1:0] w_data_q;
  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic [IDX_W-1:0]      ar_idx;
  logic [NUM_REGS-1:0]   wr_sel;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  unused_addr_bits;

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return 32'(idx) < 32'(NUM_REGS);
  endfunction

  // Byte offset within a word carries no meaning for full-word registers
  assign unused_addr_bits = ^{awaddr[1:0], araddr[1:0]};

  assign awready = ~aw_full;
  assign wready  = ~w_full;
  assign arready = ~rvalid | rready;

  assign aw_hs  = awvalid & ~aw_full;
  assign w_hs   = wvalid & ~w_full;
  assign ar_hs  = arvalid & arready;
  assign commit = aw_full & w_full & (~bvalid | bready);
  assign ar_idx = araddr[ADDR_WIDTH-1:2];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      aw_full  <= 1'b0;
      aw_idx_q <= '0;
      w_full   <= 1'b0;
      w_data_q <= '0;
    end else begin
      if (aw_hs) begin
        aw_full  <= 1'b1;
        aw_idx_q <= awaddr[ADDR_WIDTH-1:2];
      end else if (commit) begin
        aw_full <= 1'b0;
      end
      if (w_hs) begin
        w_full   <= 1'b1;
        w_data_q <= wdata;
      end else if (commit) begin
        w_full <= 1'b0;
      end
    end
  end

  // Only in-range indices can match, so an unmapped commit selects nothing
  always_comb begin
    wr_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = commit && (aw_idx_q == IDX_W'(i));
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bvalid <= 1'b0;
      bresp  <= RESP_OKAY;
      reg_wr <= '0;
    end else begin
      reg_wr <= wr_sel;
      if (commit) begin
        bvalid <= 1'b1;
        bresp  <= in_range(aw_idx_q) ? RESP_OKAY : RESP_SLVERR;
      end else if (bready) begin
        bvalid <= 1'b0;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
    logic [DATA_WIDTH-1:0] q;

    always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
        q <= '0;
      end else if (wr_sel[g]) begin
        q <= w_data_q;
      end
    end

    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = q;
  end

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (ar_idx == IDX_W'(i)) begin
        rd_word = reg_q[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Read samples the pre-edge register value, so a same-edge write is not seen
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rvalid <= 1'b0;
      rresp  <= RESP_OKAY;
      rdata  <= '0;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      rdata  <= in_range(ar_idx) ? rd_word : '0;
      rresp  <= in_range(ar_idx) ? RESP_OKAY : RESP_SLVERR;
    end else if (rready) begin
      rvalid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_axi4l_regbank.sv
// Directed bench for axi4l_regbank: reset, in/out-of-range access, B stall,
// same-edge read/write ordering and mid-transaction reset.
module tb_axi4l_regbank;

  logic         clk;
  logic         resetn;
  logic [11:0]  awaddr;
  logic         awvalid;
  logic         awready;
  logic [31:0]  wdata;
  logic         wvalid;
  logic         wready;
  logic [1:0]   bresp;
  logic         bvalid;
  logic         bready;
  logic [11:0]  araddr;
  logic         arvalid;
  logic         arready;
  logic [31:0]  rdata;
  logic [1:0]   rresp;
  logic         rvalid;
  logic         rready;
  logic [255:0] reg_q;
  logic [7:0]   reg_wr;

  int tests_run = 0;
  int tests_failed = 0;
  logic [255:0] exp_q;
  logic [31:0]  rd_val;
  logic [1:0]   rd_resp;
  logic [1:0]   wr_resp;
  logic [7:0]   wr_pulse;

  axi4l_regbank #(
    .ADDR_WIDTH(12),
    .DATA_WIDTH(32),
    .NUM_REGS  (8)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .awaddr (awaddr),
    .awvalid(awvalid),
    .awready(awready),
    .wdata  (wdata),
    .wvalid (wvalid),
    .wready (wready),
    .bresp  (bresp),
    .bvalid (bvalid),
    .bready (bready),
    .araddr (araddr),
    .arvalid(arvalid),
    .arready(arready),
    .rdata  (rdata),
    .rresp  (rresp),
    .rvalid (rvalid),
    .rready (rready),
    .reg_q  (reg_q),
    .reg_wr (reg_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full AW+W write offered together; returns the B response and reg_wr seen with it
  task automatic applyStimulus(input logic [11:0] addr, input logic [31:0] data,
                               output logic [1:0] resp, output logic [7:0] pulse);
    int  n;
    logic aw_hs;
    logic w_hs;
    awaddr  = addr;
    wdata   = data;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    bready  = 1'b1;
    n = 0;
    while ((awvalid || wvalid) && n < 20) begin
      aw_hs = awvalid & awready;
      w_hs  = wvalid & wready;
      tick();
      if (aw_hs) awvalid = 1'b0;
      if (w_hs)  wvalid = 1'b0;
      n++;
    end
    n = 0;
    while (!bvalid && n < 20) begin
      tick();
      n++;
    end
    if (!bvalid) checkOutput("write_timeout", 1, 0);
    resp  = bresp;
    pulse = reg_wr;
    tick();
  endtask

  task automatic readReg(input logic [11:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    araddr  = addr;
    arvalid = 1'b1;
    n = 0;
    while (!arready && n < 20) begin
      tick();
      n++;
    end
    tick();
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin
      tick();
      n++;
    end
    if (!rvalid) checkOutput("read_timeout", 1, 0);
    data = rdata;
    resp = rresp;
    tick();
  endtask

  initial begin
    resetn  = 1'b0;
    awaddr  = '0;
    awvalid = 1'b0;
    wdata   = '0;
    wvalid  = 1'b0;
    bready  = 1'b1;
    araddr  = '0;
    arvalid = 1'b0;
    rready  = 1'b1;
    exp_q   = '0;
    repeat (3) tick();
    resetn = 1'b1;
    tick();

    checkOutput("rst_awready", awready, 1);
    checkOutput("rst_wready", wready, 1);
    checkOutput("rst_arready", arready, 1);
    checkOutput("rst_bvalid", bvalid, 0);
    checkOutput("rst_bresp", bresp, 0);
    checkOutput("rst_rvalid", rvalid, 0);
    checkOutput("rst_rresp", rresp, 0);
    checkOutput("rst_rdata", rdata, 0);
    checkOutput("rst_reg_q", reg_q, 0);
    checkOutput("rst_reg_wr", reg_wr, 0);
    readReg(12'h004, rd_val, rd_resp);
    checkOutput("rst_read_data", rd_val, 0);
    checkOutput("rst_read_resp", rd_resp, 2'b00);

    // AW one cycle ahead of W
    awaddr  = 12'h008;
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    checkOutput("aw_first_awready", awready, 0);
    wdata  = 32'hDEADBEEF;
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    checkOutput("aw_first_no_b_yet", bvalid, 0);
    tick();
    exp_q[95:64] = 32'hDEADBEEF;
    checkOutput("aw_first_bvalid", bvalid, 1);
    checkOutput("aw_first_bresp", bresp, 2'b00);
    checkOutput("aw_first_reg_wr", reg_wr, 8'b0000_0100);
    checkOutput("aw_first_reg_q", reg_q, exp_q);
    tick();
    checkOutput("aw_first_bvalid_clr", bvalid, 0);
    checkOutput("aw_first_reg_wr_clr", reg_wr, 0);
    readReg(12'h008, rd_val, rd_resp);
    checkOutput("readback_data", rd_val, 32'hDEADBEEF);
    checkOutput("readback_resp", rd_resp, 2'b00);

    // Out-of-range write and read
    applyStimulus(12'h020, 32'hCAFEF00D, wr_resp, wr_pulse);
    checkOutput("oor_bresp", wr_resp, 2'b10);
    checkOutput("oor_reg_wr", wr_pulse, 0);
    checkOutput("oor_reg_q", reg_q, exp_q);
    readReg(12'h03C, rd_val, rd_resp);
    checkOutput("oor_rresp", rd_resp, 2'b10);
    checkOutput("oor_rdata", rd_val, 0);

    // B stalled for 5 cycles with a second pair behind the first
    bready  = 1'b0;
    awaddr  = 12'h00C;
    wdata   = 32'h11111111;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    tick();
    awaddr = 12'h010;
    wdata  = 32'h22222222;
    checkOutput("stall_full_awready", awready, 0);
    tick();
    exp_q[127:96] = 32'h11111111;
    checkOutput("stall_first_bvalid", bvalid, 1);
    checkOutput("stall_first_reg_wr", reg_wr, 8'b0000_1000);
    checkOutput("stall_first_reg_q", reg_q, exp_q);
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    checkOutput("stall_second_awready", awready, 0);
    checkOutput("stall_second_wready", wready, 0);
    checkOutput("stall_reg_wr_idle", reg_wr, 0);
    tick();
    tick();
    checkOutput("stall_bvalid_held", bvalid, 1);
    checkOutput("stall_reg_q_held", reg_q, exp_q);
    bready = 1'b1;
    tick();
    exp_q[159:128] = 32'h22222222;
    checkOutput("stall_second_bvalid", bvalid, 1);
    checkOutput("stall_second_bresp", bresp, 2'b00);
    checkOutput("stall_second_reg_wr", reg_wr, 8'b0001_0000);
    checkOutput("stall_second_reg_q", reg_q, exp_q);
    checkOutput("stall_awready_free", awready, 1);
    tick();
    checkOutput("stall_bvalid_clr", bvalid, 0);

    // Same-edge read and write of register 0
    applyStimulus(12'h000, 32'h1, wr_resp, wr_pulse);
    checkOutput("same_pre_bresp", wr_resp, 2'b00);
    awaddr  = 12'h000;
    wdata   = 32'h2;
    awvalid = 1'b1;
    wvalid  = 1'b1;
    tick();
    awvalid = 1'b0;
    wvalid  = 1'b0;
    araddr  = 12'h000;
    arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    exp_q[31:0] = 32'h2;
    checkOutput("same_edge_rvalid", rvalid, 1);
    checkOutput("same_edge_rdata_old", rdata, 32'h1);
    checkOutput("same_edge_reg_q_new", reg_q, exp_q);
    tick();
    readReg(12'h000, rd_val, rd_resp);
    checkOutput("same_edge_read_new", rd_val, 32'h2);

    // Reset with only the AW buffer filled
    awaddr  = 12'h004;
    awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    checkOutput("midrst_aw_full", awready, 0);
    resetn = 1'b0;
    #3;
    resetn = 1'b1;
    exp_q  = '0;
    checkOutput("midrst_awready", awready, 1);
    checkOutput("midrst_bvalid", bvalid, 0);
    wdata  = 32'h55555555;
    wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    tick();
    tick();
    checkOutput("midrst_no_bvalid", bvalid, 0);
    checkOutput("midrst_reg_q", reg_q, exp_q);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
